// File: rtl/core_pkg.sv
// Shared core definitions: default PC width, reset vector and next-PC source encoding.
package core_pkg;

  localparam int          PC_WIDTH         = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Source of the next PC, listed lowest to highest priority.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_RET
  } next_pc_sel_t;

  // Sign-extend a 16-bit word offset and convert it to a byte offset.
  function automatic logic [PC_WIDTH-1:0] word_offset(input logic [15:0] imm);
    word_offset = {{(PC_WIDTH-16){imm[15]}}, imm} << 2;
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Return-address stack: circular buffer addressed by a top pointer.
// A push onto a full stack overwrites the oldest entry and leaves the count saturated.
// A replace on an empty stack behaves like a push.
// The caller keeps push, pop and replace mutually exclusive.
module ras_stack
  import core_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     replace,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic             full;
  logic             grow;

  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top     = mem[ptr];
  // A replace on an empty stack needs a fresh slot, exactly like a push.
  assign grow    = push | (replace & empty);

  // Entry storage: the contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (grow) begin
        mem[ptr_inc] <= data;
      end else if (replace) begin
        mem[ptr] <= data;
      end
    end
  end

  // Top pointer and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (grow) begin
      ptr <= ptr_inc;
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter generator: PC register, next-PC selection and call/return tracking.
module pc_unit
  import core_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         branch_cond,
  input  logic                         jump,
  input  logic                         jreg,
  input  logic                         ret,
  input  logic                         link,
  input  logic [15:0]                  imm16,
  input  logic [25:0]                  target,
  input  logic [WIDTH-1:0]             rs_val,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic                         ras_underflow,
  output logic                         misalign,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] raw_tgt;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  logic             reg_target;
  next_pc_sel_t     sel;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + WIDTH'(4);
  // Only the immediate is shifted; the sum itself is never scaled.
  assign br_off   = {{(WIDTH-16){imm16[15]}}, imm16} << 2;
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = {pc_plus4[WIDTH-1:28], target, 2'b00};

  // Returns prefer the predicted address; with nothing stacked they fall back to rs_val.
  assign raw_tgt  = (ret && !ras_empty) ? ras_top : rs_val;

  // Next-PC source priority: ret > jreg > jump > taken branch > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (ret) begin
      sel = SEL_RET;
    end else if (jreg) begin
      sel = SEL_JR;
    end else if (jump) begin
      sel = SEL_J;
    end else if (branch && branch_cond) begin
      sel = SEL_BR;
    end
  end

  assign reg_target = (sel == SEL_RET) || (sel == SEL_JR);

  // Next-PC mux; register-sourced targets are forced to word alignment.
  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_RET, SEL_JR: next_pc = {raw_tgt[WIDTH-1:2], 2'b00};
      SEL_J:           next_pc = j_tgt;
      SEL_BR:          next_pc = br_tgt;
      default:         next_pc = pc_plus4;
    endcase
  end

  // A stalled cycle leaves the stack untouched; reset is handled inside the stack.
  assign ras_push    = !stall && link && !ret;
  assign ras_pop     = !stall && ret && !link;
  assign ras_replace = !stall && ret && link;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .data    (pc_plus4),
    .top     (ras_top),
    .count   (ras_count),
    .empty   (ras_empty)
  );

  // Architectural PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (!stall) begin
      pc_q <= next_pc;
    end
  end

  // One-cycle status pulses describing the instruction just retired.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      ras_underflow <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      ras_underflow <= ret && !link && ras_empty;
      misalign      <= reg_target && (raw_tgt[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed sequences with literal expectations, then random traffic,
// all checked every cycle against a queue-based reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch, branch_cond, jump, jreg, ret, link;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] rs_val;
  logic [31:0] pc, pc_plus4;
  logic        ras_underflow, misalign;
  logic [2:0]  ras_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .WIDTH     (32),
    .RESET_PC  (32'h0000_3000),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .branch_cond   (branch_cond),
    .jump          (jump),
    .jreg          (jreg),
    .ret           (ret),
    .link          (link),
    .imm16         (imm16),
    .target        (target),
    .rs_val        (rs_val),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_underflow (ras_underflow),
    .misalign      (misalign),
    .ras_count     (ras_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue, newest entry at the back, at most 4 entries.
  logic [31:0] m_pc;
  logic        m_uf, m_mis;
  logic [31:0] q[$];
  bit          started = 0;

  always @(posedge clk) begin : model
    logic [31:0] p4, raw, nxt;
    if (rst) begin
      m_pc = 32'h3000; m_uf = 0; m_mis = 0; q.delete(); started = 1;
    end else if (started) begin
      if (stall) begin
        m_uf = 0; m_mis = 0;
      end else begin
        p4  = m_pc + 32'd4;
        raw = rs_val;
        if (ret && q.size() > 0) raw = q[$];
        if (ret || jreg)               nxt = raw & ~32'd3;
        else if (jump)                 nxt = {p4[31:28], target, 2'b00};
        else if (branch && branch_cond) nxt = p4 + 32'(signed'(imm16)) * 4;
        else                           nxt = p4;
        m_mis = (ret || jreg) && (raw[1:0] != 2'b00);
        m_uf  = ret && !link && (q.size() == 0);
        if (link && !ret) begin
          q.push_back(p4);
          if (q.size() > 4) void'(q.pop_front());
        end else if (ret && !link) begin
          if (q.size() > 0) void'(q.pop_back());
        end else if (ret && link) begin
          if (q.size() == 0) q.push_back(p4);
          else q[q.size()-1] = p4;
        end
        m_pc = nxt;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("ras_count", 32'(ras_count), 32'(q.size()));
      chk("ras_underflow", 32'(ras_underflow), 32'(m_uf));
      chk("misalign", 32'(misalign), 32'(m_mis));
    end
  end

  task automatic clr();
    rst = 0; stall = 0; branch = 0; branch_cond = 0; jump = 0; jreg = 0;
    ret = 0; link = 0; imm16 = '0; target = '0; rs_val = '0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr(); rst = 1; tick(); clr();
  endtask

  initial begin
    clr();
    // Reset held two cycles, then sequential fetch.
    rst = 1; tick(2);
    chk("reset_pc", pc, 32'h3000);
    chk("model_reset_pc", m_pc, 32'h3000);
    chk("reset_count", 32'(ras_count), 0);
    clr();
    tick(); chk("seq1", pc, 32'h3004);
    tick(); chk("seq2", pc, 32'h3008);
    tick(); chk("seq3", pc, 32'h300C);
    chk("seq_count", 32'(ras_count), 0);
    tick(); chk("seq4", pc, 32'h3010);

    // Branches from 0x3010.
    branch = 1; branch_cond = 1; imm16 = 16'hFFFF; tick();
    chk("br_back", pc, 32'h3010);
    chk("model_br_back", m_pc, 32'h3010);
    branch_cond = 0; imm16 = 16'h0003; tick();
    chk("br_not_taken", pc, 32'h3014);
    clr(); jreg = 1; rs_val = 32'h3010; tick();
    clr(); branch = 1; branch_cond = 1; imm16 = 16'h0003; tick();
    chk("br_fwd", pc, 32'h3020);

    // Jump, then stall with jump still asserted.
    do_reset();
    chk("jmp_start", pc, 32'h3000);
    jump = 1; target = 26'h0000100; tick();
    chk("jump", pc, 32'h400);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_hold", pc, 32'h400);
    end

    // Call then return.
    do_reset();
    jump = 1; link = 1; target = 26'h0000100; tick();
    chk("call_pc", pc, 32'h400);
    chk("call_count", 32'(ras_count), 1);
    chk("model_top", q[$], 32'h3004);
    clr(); tick(2);
    ret = 1; rs_val = 32'hDEAD0000; tick();
    chk("ret_pc", pc, 32'h3004);
    chk("ret_count", 32'(ras_count), 0);

    // Overflow: five pushes of 0x10..0x50, then four returns, then an empty return.
    do_reset();
    jreg = 1; rs_val = 32'hC; tick();
    for (int k = 1; k <= 5; k++) begin
      jreg = 1; link = 1; rs_val = 32'hC + 32'(16 * k); tick();
    end
    chk("ovf_count", 32'(ras_count), 4);
    clr();
    for (int i = 0; i < 4; i++) begin
      ret = 1; rs_val = 32'hDEAD0000; tick();
      chk("ovf_ret", pc, 32'h50 - 32'(16 * i));
    end
    chk("empty_count", 32'(ras_count), 0);
    ret = 1; rs_val = 32'h1236; tick();
    chk("uf_pc", pc, 32'h1234);
    chk("uf_pulse", 32'(ras_underflow), 1);
    chk("mis_pulse", 32'(misalign), 1);
    clr(); tick();
    chk("uf_clear", 32'(ras_underflow), 0);
    chk("mis_clear", 32'(misalign), 0);

    // Priority: ret beats jreg, jump and branch.
    do_reset();
    jump = 1; link = 1; target = 26'h0000100; tick();
    clr(); ret = 1; jreg = 1; jump = 1; branch = 1; branch_cond = 1;
    rs_val = 32'h8000; target = 26'h200; imm16 = 16'h10; tick();
    chk("prio_ret", pc, 32'h3004);

    // Reset beats stall and link.
    clr(); link = 1; jump = 1; target = 26'h40; tick(2);
    rst = 1; stall = 1; link = 1; tick();
    chk("rst_mid_pc", pc, 32'h3000);
    chk("rst_mid_count", 32'(ras_count), 0);

    // pc_plus4 wrap at the top of the address space.
    clr(); jreg = 1; rs_val = 32'hFFFF_FFFC; tick();
    chk("wrap_p4", pc_plus4, 32'h0);
    clr(); tick();
    chk("wrap_pc", pc, 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      branch      = $urandom_range(0, 1) == 1;
      branch_cond = $urandom_range(0, 1) == 1;
      jump        = ($urandom_range(0, 5) == 0);
      jreg        = ($urandom_range(0, 7) == 0);
      ret         = ($urandom_range(0, 5) == 0);
      link        = ($urandom_range(0, 4) == 0);
      imm16       = 16'($urandom);
      target      = 26'($urandom);
      rs_val      = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'($urandom_range(0, 4095)) << 2);
      tick();
    end

    clr(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
